// File: rtl/bus_downsizer.sv
// bus_downsizer
//   Width-reducing stream adapter. Accepts one S_DATA_WIDTH-bit word per
//   valid/ready handshake and emits it as RATIO = S_DATA_WIDTH/M_DATA_WIDTH
//   narrow beats, most-significant slice first. This is the transmit-side
//   counterpart of bus_upsizer, so a downsizer feeding an upsizer with the
//   same parameters reproduces the original word.
//
// Parameters
//   S_DATA_WIDTH : wide input word width (integer multiple of M_DATA_WIDTH)
//   M_DATA_WIDTH : narrow output beat width (RATIO must be >= 2)
//
// Ports
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   s_val  : s_data is valid
//   s_data : wide input word
//   s_rdy  : word is accepted this cycle (combinational from m_rdy only)
//   m_val  : m_data is valid (registered)
//   m_data : current narrow beat (registered)
//   m_last : current beat is the last slice of its word (registered)
//   m_rdy  : downstream accepts m_data this cycle

module bus_downsizer #(
    parameter int S_DATA_WIDTH = 32,
    parameter int M_DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_val,
    input  logic [S_DATA_WIDTH-1:0] s_data,
    output logic                    s_rdy,
    output logic                    m_val,
    output logic [M_DATA_WIDTH-1:0] m_data,
    output logic                    m_last,
    input  logic                    m_rdy
);

    localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int CW    = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [S_DATA_WIDTH-1:0] hold;
    logic [S_DATA_WIDTH-1:0] next_hold;
    logic [CW-1:0]           k;
    logic [CW-1:0]           next_k;
    logic                    s_hs;
    logic                    m_hs;

    // A new word can enter while idle, or on the cycle the final beat leaves.
    assign s_rdy = (state == IDLE) || (m_rdy && m_last);

    assign s_hs = s_val && s_rdy;
    assign m_hs = m_val && m_rdy;

    // A slave handshake can only coincide with the final-beat handshake, so
    // the load below simply overrides the return-to-idle decision.
    always_comb begin
        next_state = state;
        next_hold  = hold;
        next_k     = k;
        if (m_hs) begin
            if (k == LAST_BEAT) begin
                next_state = IDLE;
                next_k     = '0;
            end else begin
                next_k = k + CW'(1);
            end
        end
        if (s_hs) begin
            next_state = SEND;
            next_hold  = s_data;
            next_k     = '0;
        end
    end

    // Outputs are registered from the next-state values so that m_val,
    // m_data and m_last have no combinational path from the inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            hold   <= '0;
            k      <= '0;
            m_val  <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
        end else begin
            state  <= next_state;
            hold   <= next_hold;
            k      <= next_k;
            m_val  <= (next_state == SEND);
            m_last <= (next_state == SEND) && (next_k == LAST_BEAT);
            m_data <= next_hold[S_DATA_WIDTH - 1 - M_DATA_WIDTH * int'(next_k) -: M_DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_bus_downsizer.sv
// tb_bus_downsizer
//   Self-checking bench for bus_downsizer (S=32, M=8). A table of per-cycle
//   vectors covers the directed corner cases; a randomized phase checks every
//   cycle against a beat-queue reference model and reassembles beats into
//   words to confirm a lossless, in-order round trip.

module tb_bus_downsizer;

    localparam int S = 32;
    localparam int M = 8;
    localparam int RATIO = S / M;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         s_val = 1'b0;
    logic [S-1:0] s_data = '0;
    logic         s_rdy;
    logic         m_val;
    logic [M-1:0] m_data;
    logic         m_last;
    logic         m_rdy = 1'b0;

    int tests = 0;
    int failed = 0;

    bus_downsizer #(
        .S_DATA_WIDTH(S),
        .M_DATA_WIDTH(M)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .s_val  (s_val),
        .s_data (s_data),
        .s_rdy  (s_rdy),
        .m_val  (m_val),
        .m_data (m_data),
        .m_last (m_last),
        .m_rdy  (m_rdy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic         sv;
        logic [S-1:0] sd;
        logic         mr;
        logic         ev;
        logic [M-1:0] ed;
        logic         el;
        logic         er;
        logic         cd;
        logic         cr;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [M-1:0] data;
        logic         last;
    } beat_t;

    beat_t        beats[$];
    logic [S-1:0] words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic sv, input logic [S-1:0] sd, input logic mr,
                       input logic ev, input logic [M-1:0] ed, input logic el, input logic er,
                       input logic cd, input logic cr);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.mr = mr;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.cd = cd; v.cr = cr;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic         pend;
        logic         mh;
        logic         sh;
        logic         exp_rdy;
        logic [S-1:0] asm_word;
        logic [S-1:0] w;
        beat_t        b;

        // rows: rst sv sd mr | m_val m_data m_last s_rdy | chk_data chk_rdy
        // reset state
        add(1, 0, 32'h0,        1, 0, 8'h00, 0, 1, 1, 1);
        // basic split
        add(0, 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hA1, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hB2, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hC3, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hD4, 1, 1, 1, 1);
        add(0, 0, 32'h0,        1, 0, 8'h00, 0, 1, 0, 1);
        // back-to-back, s_val held high
        add(0, 1, 32'h11223344, 1, 0, 8'h00, 0, 1, 0, 1);
        add(0, 1, 32'h55667788, 1, 1, 8'h11, 0, 0, 1, 1);
        add(0, 1, 32'h55667788, 1, 1, 8'h22, 0, 0, 1, 1);
        add(0, 1, 32'h55667788, 1, 1, 8'h33, 0, 0, 1, 1);
        add(0, 1, 32'h55667788, 1, 1, 8'h44, 1, 1, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h55, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h66, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h77, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h88, 1, 1, 1, 1);
        add(0, 0, 32'h0,        1, 0, 8'h00, 0, 1, 0, 1);
        // backpressure on B2
        add(0, 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 1, 0, 1);
        add(0, 0, 32'h0,        1, 1, 8'hA1, 0, 0, 1, 1);
        add(0, 0, 32'h0,        0, 1, 8'hB2, 0, 0, 1, 1);
        add(0, 0, 32'h0,        0, 1, 8'hB2, 0, 0, 1, 1);
        add(0, 0, 32'h0,        0, 1, 8'hB2, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hB2, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hC3, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hD4, 1, 1, 1, 1);
        add(0, 0, 32'h0,        1, 0, 8'h00, 0, 1, 0, 1);
        // ignored input during beat 2
        add(0, 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 1, 0, 1);
        add(0, 0, 32'h0,        1, 1, 8'hA1, 0, 0, 1, 1);
        add(0, 1, 32'hDEADBEEF, 1, 1, 8'hB2, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hC3, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'hD4, 1, 1, 1, 1);
        add(0, 0, 32'h0,        1, 0, 8'h00, 0, 1, 0, 1);
        // reset mid-word, with s_val high during reset
        add(0, 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 1, 0, 1);
        add(0, 0, 32'h0,        1, 1, 8'hA1, 0, 0, 1, 1);
        add(1, 1, 32'h12345678, 1, 1, 8'hB2, 0, 0, 1, 0);
        add(0, 0, 32'h0,        1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 1, 32'h0F0E0D0C, 1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h0F, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h0E, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h0D, 0, 0, 1, 1);
        add(0, 0, 32'h0,        1, 1, 8'h0C, 1, 1, 1, 1);
        add(0, 0, 32'h0,        1, 0, 8'h00, 0, 1, 0, 1);

        reset = 1'b1;
        tick();
        tick();

        foreach (vecs[i]) begin
            reset  = vecs[i].rst;
            s_val  = vecs[i].sv;
            s_data = vecs[i].sd;
            m_rdy  = vecs[i].mr;
            #1;
            check($sformatf("vec%0d m_val", i), 32'(m_val), 32'(vecs[i].ev));
            check($sformatf("vec%0d m_last", i), 32'(m_last), 32'(vecs[i].el));
            if (vecs[i].cd) check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].ed));
            if (vecs[i].cr) check($sformatf("vec%0d s_rdy", i), 32'(s_rdy), 32'(vecs[i].er));
            tick();
        end

        // Randomized phase: the model holds the beats still owed downstream.
        reset = 1'b0;
        s_val = 1'b0;
        pend = 1'b0;
        asm_word = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_rdy = ($urandom_range(0, 3) != 0);
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend   = 1'b1;
                s_data = $urandom;
            end
            s_val = pend;
            #1;
            exp_rdy = (beats.size() == 0) || (beats.size() == 1 && m_rdy);
            check("rnd m_val", 32'(m_val), 32'(beats.size() != 0));
            check("rnd s_rdy", 32'(s_rdy), 32'(exp_rdy));
            if (beats.size() != 0) begin
                check("rnd m_data", 32'(m_data), 32'(beats[0].data));
                check("rnd m_last", 32'(m_last), 32'(beats[0].last));
            end
            mh = (beats.size() != 0) && m_rdy;
            sh = s_val && exp_rdy;
            if (mh) begin
                b = beats.pop_front();
                asm_word = {asm_word[S-M-1:0], m_data};
                if (b.last) begin
                    w = words.pop_front();
                    check("loopback word", asm_word, w);
                end
            end
            if (sh) begin
                w = s_data;
                words.push_back(w);
                for (int j = 0; j < RATIO; j++) begin
                    b.data = w[S-1-j*M -: M];
                    b.last = (j == RATIO - 1);
                    beats.push_back(b);
                end
                pend = 1'b0;
            end
            tick();
        end

        // Drain, bounded by a cycle budget.
        s_val = 1'b0;
        m_rdy = 1'b1;
        for (int cyc = 0; cyc < 2 * RATIO && beats.size() != 0; cyc++) begin
            #1;
            check("drain m_data", 32'(m_data), 32'(beats[0].data));
            b = beats.pop_front();
            asm_word = {asm_word[S-M-1:0], m_data};
            if (b.last) begin
                w = words.pop_front();
                check("drain word", asm_word, w);
            end
            tick();
        end
        check("drained m_val", 32'(m_val), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
